// File: rtl/cnn_ram_loader.sv
// Loads feature-map, weight and bias RAMs from a shared source memory.
// Also handles on-demand kernel swaps into a bank and single feature-map writes.
module cnn_ram_loader #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned FM_AW         = 19,
  parameter int unsigned W_AW          = 13,
  parameter int unsigned SRC_AW        = 20,
  parameter int unsigned NUM_BANKS     = 2,
  parameter int unsigned BANK_WORDS    = 363,
  parameter int unsigned FM_INIT_WORDS = 154587,
  parameter int unsigned NUM_KERNELS   = 96,
  parameter int unsigned SRC_FM_BASE   = 0,
  parameter int unsigned SRC_W_BASE    = 2**19,
  parameter int unsigned SRC_B_BASE    = 2**19 + 2**17,
  localparam int unsigned BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [FM_AW-1:0]  cmd_fm_addr,
  input  logic [DATA_W-1:0] cmd_fm_data,
  output logic              src_rd,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              fm_we,
  output logic [FM_AW-1:0]  fm_addr,
  output logic [DATA_W-1:0] fm_data,
  output logic              w_we,
  output logic [W_AW-1:0]   w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              b_we,
  output logic [BANK_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data,
  output logic              done,
  output logic              err,
  output logic              init_done,
  output logic [15:0]       kernel_idx
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LD_FM = 3'd1;
  localparam logic [2:0] S_LD_W  = 3'd2;
  localparam logic [2:0] S_LD_B  = 3'd3;
  localparam logic [2:0] S_UPD_W = 3'd4;
  localparam logic [2:0] S_UPD_B = 3'd5;
  localparam logic [2:0] S_FM_WR = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  localparam logic [1:0] TGT_NONE = 2'd0;
  localparam logic [1:0] TGT_FM   = 2'd1;
  localparam logic [1:0] TGT_W    = 2'd2;
  localparam logic [1:0] TGT_B    = 2'd3;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [15:0]       kidx_d;
  logic              init_d;
  logic              rd_d;
  logic [SRC_AW-1:0] raddr_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [CNT_W-1:0]  dst_q, dst_d;
  logic              fm_we_d, w_we_d, b_we_d;
  logic [FM_AW-1:0]  fm_addr_d;
  logic [W_AW-1:0]   w_addr_d;
  logic [BANK_W-1:0] b_addr_d;
  logic [DATA_W-1:0] fm_wdata_q, fm_wdata_d;
  logic              fm_ld_q, fm_ld_d;
  logic              done_d, err_d, ready_d;
  logic              cmd_bad;

  // Write data rides straight from the source bus in the strobe cycle after each read
  assign fm_data = fm_ld_q ? src_data : fm_wdata_q;
  assign w_data  = w_we ? src_data : '0;
  assign b_data  = b_we ? src_data : '0;

  assign cmd_bad = (cmd_op == 2'b11) || (32'(cmd_bank) >= NUM_BANKS) ||
                   ((cmd_op == 2'b01) && (!init_done || (32'(kernel_idx) >= NUM_KERNELS)));

  // Next-state, read issue and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bank_d     = bank_q;
    kidx_d     = kernel_idx;
    init_d     = init_done;
    err_d      = 1'b0;
    fm_we_d    = src_rd && (tgt_q == TGT_FM);
    w_we_d     = src_rd && (tgt_q == TGT_W);
    b_we_d     = src_rd && (tgt_q == TGT_B);
    fm_ld_d    = fm_we_d;
    fm_wdata_d = fm_wdata_q;
    fm_addr_d  = fm_we_d ? FM_AW'(dst_q) : fm_addr;
    w_addr_d   = w_we_d ? W_AW'(dst_q) : w_addr;
    b_addr_d   = b_we_d ? BANK_W'(dst_q) : b_addr;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          bank_d = cmd_bank;
          cnt_d  = '0;
          if (cmd_bad) begin
            state_d = S_FIN;
            err_d   = 1'b1;
          end else begin
            case (cmd_op)
              2'b00:   state_d = S_LD_FM;
              2'b01:   state_d = S_UPD_W;
              default: begin
                state_d    = S_FM_WR;
                fm_we_d    = 1'b1;
                fm_ld_d    = 1'b0;
                fm_addr_d  = cmd_fm_addr;
                fm_wdata_d = cmd_fm_data;
              end
            endcase
          end
        end
      end
      S_LD_FM: begin
        if (cnt_q == CNT_W'(FM_INIT_WORDS - 1)) begin
          state_d = S_LD_W;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LD_W: begin
        if (cnt_q == CNT_W'(NUM_BANKS * BANK_WORDS - 1)) begin
          state_d = S_LD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LD_B: begin
        // Final count is a drain cycle for the last bias write
        if (cnt_q == CNT_W'(NUM_BANKS)) begin
          state_d = S_FIN;
          init_d  = 1'b1;
          kidx_d  = 16'(NUM_BANKS);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UPD_W: begin
        if (cnt_q == CNT_W'(BANK_WORDS - 1)) begin
          state_d = S_UPD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_UPD_B: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
          kidx_d  = kernel_idx + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FM_WR: state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Read issued in the cycle the next state/count describes
    rd_d    = 1'b0;
    raddr_d = '0;
    tgt_d   = TGT_NONE;
    dst_d   = '0;
    case (state_d)
      S_LD_FM: begin
        rd_d    = 1'b1;
        raddr_d = SRC_AW'(SRC_FM_BASE) + SRC_AW'(cnt_d);
        tgt_d   = TGT_FM;
        dst_d   = cnt_d;
      end
      S_LD_W: begin
        rd_d    = 1'b1;
        raddr_d = SRC_AW'(SRC_W_BASE) + SRC_AW'(cnt_d);
        tgt_d   = TGT_W;
        dst_d   = cnt_d;
      end
      S_LD_B: begin
        if (cnt_d < CNT_W'(NUM_BANKS)) begin
          rd_d    = 1'b1;
          raddr_d = SRC_AW'(SRC_B_BASE) + SRC_AW'(cnt_d);
          tgt_d   = TGT_B;
          dst_d   = cnt_d;
        end
      end
      S_UPD_W: begin
        rd_d    = 1'b1;
        raddr_d = SRC_AW'(SRC_W_BASE) + SRC_AW'(kidx_d) * SRC_AW'(BANK_WORDS) + SRC_AW'(cnt_d);
        tgt_d   = TGT_W;
        dst_d   = CNT_W'(bank_d) * CNT_W'(BANK_WORDS) + cnt_d;
      end
      S_UPD_B: begin
        if (cnt_d == '0) begin
          rd_d    = 1'b1;
          raddr_d = SRC_AW'(SRC_B_BASE) + SRC_AW'(kidx_d);
          tgt_d   = TGT_B;
          dst_d   = CNT_W'(bank_d);
        end
      end
      default: ;
    endcase

    done_d  = (state_d == S_FIN);
    ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      tgt_q      <= TGT_NONE;
      dst_q      <= '0;
      fm_wdata_q <= '0;
      fm_ld_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      src_rd     <= 1'b0;
      src_addr   <= '0;
      fm_we      <= 1'b0;
      fm_addr    <= '0;
      w_we       <= 1'b0;
      w_addr     <= '0;
      b_we       <= 1'b0;
      b_addr     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      init_done  <= 1'b0;
      kernel_idx <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      tgt_q      <= tgt_d;
      dst_q      <= dst_d;
      fm_wdata_q <= fm_wdata_d;
      fm_ld_q    <= fm_ld_d;
      cmd_ready  <= ready_d;
      src_rd     <= rd_d;
      src_addr   <= raddr_d;
      fm_we      <= fm_we_d;
      fm_addr    <= fm_addr_d;
      w_we       <= w_we_d;
      w_addr     <= w_addr_d;
      b_we       <= b_we_d;
      b_addr     <= b_addr_d;
      done       <= done_d;
      err        <= err_d;
      init_done  <= init_d;
      kernel_idx <= kidx_d;
    end
  end

endmodule

// File: tb/tb_cnn_ram_loader.sv
// Directed bench for cnn_ram_loader with a scoreboard of expected RAM writes.
module tb_cnn_ram_loader;

  localparam int unsigned DW      = 16;
  localparam int unsigned FMA     = 19;
  localparam int unsigned WA      = 13;
  localparam int unsigned SA      = 20;
  localparam int unsigned NB      = 2;
  localparam int unsigned BW      = 4;
  localparam int unsigned FMN     = 6;
  localparam int unsigned NK      = 4;
  localparam int unsigned W_BASE  = 2**19;
  localparam int unsigned B_BASE  = 2**19 + 2**17;

  localparam logic [1:0] K_FM = 2'd1;
  localparam logic [1:0] K_W  = 2'd2;
  localparam logic [1:0] K_B  = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  logic           clk, rst;
  logic           cmd_valid, cmd_ready;
  logic [1:0]     cmd_op;
  logic [0:0]     cmd_bank;
  logic [FMA-1:0] cmd_fm_addr;
  logic [DW-1:0]  cmd_fm_data;
  logic           src_rd;
  logic [SA-1:0]  src_addr;
  logic [DW-1:0]  src_data;
  logic           fm_we, w_we, b_we;
  logic [FMA-1:0] fm_addr;
  logic [WA-1:0]  w_addr;
  logic [0:0]     b_addr;
  logic [DW-1:0]  fm_data, w_data, b_data;
  logic           done, err, init_done;
  logic [15:0]    kernel_idx;

  int  checks = 0;
  int  passed = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  cnn_ram_loader #(
    .DATA_W(DW), .FM_AW(FMA), .W_AW(WA), .SRC_AW(SA), .NUM_BANKS(NB),
    .BANK_WORDS(BW), .FM_INIT_WORDS(FMN), .NUM_KERNELS(NK)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
    .cmd_fm_addr(cmd_fm_addr), .cmd_fm_data(cmd_fm_data),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .fm_we(fm_we), .fm_addr(fm_addr), .fm_data(fm_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .done(done), .err(err), .init_done(init_done), .kernel_idx(kernel_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory: returns the low address bits one cycle after a read
  always @(posedge clk or posedge rst) begin
    if (rst) src_data <= 16'h0;
    else     src_data <= src_rd ? src_addr[15:0] : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int unsigned addr, input int unsigned data);
    wr_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = 16'(data);
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    for (int i = 0; i < int'(FMN); i++)     push(K_FM, i, i);
    for (int j = 0; j < int'(NB * BW); j++) push(K_W, j, W_BASE + j);
    for (int k = 0; k < int'(NB); k++)      push(K_B, k, B_BASE + k);
  endtask

  task automatic push_update(input int unsigned bank, input int unsigned kidx);
    for (int j = 0; j < int'(BW); j++) push(K_W, bank * BW + j, W_BASE + kidx * BW + j);
    push(K_B, bank, B_BASE + kidx);
  endtask

  // Scoreboard: every write strobe must match the next expected write
  always @(negedge clk) begin
    if (!rst && (fm_we || w_we || b_we)) begin
      chk("strobe_onehot", 32'(fm_we) + 32'(w_we) + 32'(b_we), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (fm_we) begin
          chk("wr_kind", 32'(K_FM), 32'(mon_e.kind));
          chk("fm_addr", 32'(fm_addr), mon_e.addr);
          chk("fm_data", 32'(fm_data), 32'(mon_e.data));
        end else if (w_we) begin
          chk("wr_kind", 32'(K_W), 32'(mon_e.kind));
          chk("w_addr", 32'(w_addr), mon_e.addr);
          chk("w_data", 32'(w_data), 32'(mon_e.data));
        end else begin
          chk("wr_kind", 32'(K_B), 32'(mon_e.kind));
          chk("b_addr", 32'(b_addr), mon_e.addr);
          chk("b_data", 32'(b_data), 32'(mon_e.data));
        end
      end
    end
  end

  // Issue one command from a negedge and time its done pulse relative to acceptance
  task automatic run_cmd(input logic [1:0] op, input logic bank, input logic [FMA-1:0] fa,
                         input logic [DW-1:0] fd, input int exp_cyc, input logic exp_err,
                         input int exp_strobes, input bit hold, input string tag);
    int n = 0;
    int strobes = 0;
    bit got = 0;
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_bank = bank; cmd_fm_addr = fa; cmd_fm_data = fd;
    cmd_valid = 1'b1;
    @(posedge clk);
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) cmd_valid = 1'b0;
      if (fm_we || w_we || b_we) strobes++;
      if (done) got = 1;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_cyc));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bank = 1'b0;
    cmd_fm_addr = '0; cmd_fm_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_strobes", 32'(fm_we | w_we | b_we | src_rd | done | err), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_kidx", 32'(kernel_idx), 32'd0);
    chk("rst_addrs", 32'(src_addr) | 32'(fm_addr) | 32'(w_addr) | 32'(b_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(2'b01, 1'b0, '0, '0, 1, 1'b1, 0, 0, "upd_noinit");
    chk("upd_noinit_kidx", 32'(kernel_idx), 32'd0);

    push_init();
    run_cmd(2'b00, 1'b0, '0, '0, 18, 1'b0, 16, 0, "init");
    chk("init_q_empty", 32'(exp_q.size()), 32'd0);
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_kidx", 32'(kernel_idx), 32'(NB));

    push_update(1, 2);
    run_cmd(2'b01, 1'b1, '0, '0, 7, 1'b0, 5, 0, "upd_b1");
    chk("upd_b1_kidx", 32'(kernel_idx), 32'd3);

    push_update(0, 3);
    run_cmd(2'b01, 1'b0, '0, '0, 7, 1'b0, 5, 0, "upd_b0");
    chk("upd_b0_kidx", 32'(kernel_idx), 32'd4);

    run_cmd(2'b01, 1'b1, '0, '0, 1, 1'b1, 0, 0, "upd_exhausted");
    chk("upd_exhausted_kidx", 32'(kernel_idx), 32'd4);

    run_cmd(2'b11, 1'b0, '0, '0, 1, 1'b1, 0, 0, "op_reserved");

    push(K_FM, 32'h1234, 32'hBEEF);
    run_cmd(2'b10, 1'b0, 19'h01234, 16'hBEEF, 2, 1'b0, 1, 1, "fm_write");
    repeat (3) @(negedge clk);
    chk("fm_write_no_requeue", 32'(exp_q.size()) | 32'(src_rd) | 32'(done), 32'd0);

    // Abort an init at its third feature-map write
    push_init();
    cmd_op = 2'b00; cmd_bank = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (fm_we && fm_addr == FMA'(2)) found = 1;
    end
    chk("abort_third_fm_seen", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", 32'(fm_we | w_we | b_we | src_rd | done | err), 32'd0);
    chk("abort_init_done", 32'(init_done), 32'd0);
    chk("abort_kidx", 32'(kernel_idx), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_outputs", 32'(fm_addr) | 32'(fm_data) | 32'(src_addr), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_quiet", 32'(fm_we | w_we | b_we | src_rd), 32'd0);

    push_init();
    run_cmd(2'b00, 1'b0, '0, '0, 18, 1'b0, 16, 0, "reinit");
    chk("reinit_q_empty", 32'(exp_q.size()), 32'd0);
    chk("reinit_kidx", 32'(kernel_idx), 32'(NB));
    chk("reinit_done", 32'(init_done), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cnn_ram_loader.md
CNN_RAM_LOADER -- requirements
Module: cnn_ram_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, RAM data word width.
REQ-002 SHALL have parameter FM_AW, default 19, feature-map RAM address width.
REQ-003 SHALL have parameter W_AW, default 13, weight RAM address width.
REQ-004 SHALL have parameter SRC_AW, default 20, source memory address width.
REQ-005 SHALL have parameter NUM_BANKS, default 2, number of weight/bias banks; BANK_W = max(1, clog2(NUM_BANKS)).
REQ-006 SHALL have parameter BANK_WORDS, default 363, weight words per kernel (11*11*3).
REQ-007 SHALL have parameter FM_INIT_WORDS, default 154587, FM words in the initial load (227*227*3).
REQ-008 SHALL have parameter NUM_KERNELS, default 96, kernels available in source memory.
REQ-009 SHALL have parameters SRC_FM_BASE, SRC_W_BASE, SRC_B_BASE, defaults 0, 2^19, 2^19+2^17, source region bases.
REQ-010 SHALL have ports: clk in 1 clock; rst in 1 asynchronous active-high reset.
REQ-011 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 2 (00 init, 01 kernel update, 10 FM write, 11 reserved); cmd_bank in BANK_W; cmd_fm_addr in FM_AW; cmd_fm_data in DATA_W.
REQ-012 SHALL have ports: src_rd out 1; src_addr out SRC_AW; src_data in DATA_W, valid exactly 1 cycle after src_rd.
REQ-013 SHALL have ports: fm_we out 1, fm_addr out FM_AW, fm_data out DATA_W; w_we out 1, w_addr out W_AW, w_data out DATA_W; b_we out 1, b_addr out BANK_W, b_data out DATA_W.
REQ-014 SHALL have ports: done out 1 (one-cycle pulse); err out 1 (valid with done); init_done out 1; kernel_idx out 16 (next source kernel to load).

Function
REQ-015 SHALL be an FSM with states IDLE, LD_FM, LD_W, LD_B, UPD_W, UPD_B, FM_WR, FIN; cmd_ready=1 only in IDLE.
REQ-016 SHALL accept a command when cmd_valid && cmd_ready; all cmd_* fields captured on that edge.
REQ-017 Init (op 00): SHALL read FM source words SRC_FM_BASE+i, i=0..FM_INIT_WORDS-1, writing fm_addr=i; then weights SRC_W_BASE+j, j=0..NUM_BANKS*BANK_WORDS-1, writing w_addr=j; then biases SRC_B_BASE+k, k=0..NUM_BANKS-1, writing b_addr=k.
REQ-018 SHALL issue one src_rd per cycle with no gaps across LD_FM->LD_W->LD_B; each RAM write strobe asserts the cycle after its read, data = src_data.
REQ-019 On init completion SHALL set init_done=1 and kernel_idx=NUM_BANKS; a repeated init SHALL reload everything and reset kernel_idx to NUM_BANKS.
REQ-020 Kernel update (op 01): SHALL read SRC_W_BASE+kernel_idx*BANK_WORDS+j, j=0..BANK_WORDS-1, writing w_addr=cmd_bank*BANK_WORDS+j; then SRC_B_BASE+kernel_idx to b_addr=cmd_bank; then kernel_idx increments by 1.
REQ-021 FM write (op 10): SHALL assert fm_we for exactly one cycle the cycle after acceptance with fm_addr=cmd_fm_addr, fm_data=cmd_fm_data; no src_rd.
REQ-022 done SHALL pulse for 1 cycle (state FIN) the cycle after the last write strobe; FSM returns to IDLE the following cycle.
REQ-023 Error: op 11, op 01 with init_done=0, op 01 with kernel_idx>=NUM_KERNELS, or cmd_bank>=NUM_BANKS SHALL perform no reads/writes and pulse done with err=1 the cycle after acceptance; err=0 on all other done pulses.
REQ-024 Address arithmetic SHALL be computed at SRC_AW/W_AW width, truncated; at most one of fm_we, w_we, b_we SHALL be high per cycle.
REQ-025 cmd_valid while busy SHALL be ignored (not queued).

Reset
REQ-026 rst SHALL asynchronously force IDLE, cmd_ready=1, all strobes/done/err/init_done=0, kernel_idx=0, all address/data outputs=0.
REQ-027 rst mid-operation SHALL abort immediately; no write strobe in the cycle after rst deasserts.

Verification (params DATA_W=16, NUM_BANKS=2, BANK_WORDS=4, FM_INIT_WORDS=6, NUM_KERNELS=4, src_data = address low 16 bits)
REQ-028 Init -> fm_addr 0..5 then w_addr 0..7 then b_addr 0,1, 16 consecutive strobes, done at cycle 18 after acceptance, init_done=1, kernel_idx=2.
REQ-029 Update bank 1 after init -> w_addr 4..7 with data SRC_W_BASE+8..11, b_addr=1 data SRC_B_BASE+2, kernel_idx=3, err=0.
REQ-030 Update before init -> no strobes, done+err=1 cycle after acceptance; third update after init (kernel_idx=4) -> err=1, kernel_idx stays 4.
REQ-031 FM write addr 0x1234 data 0xBEEF -> single fm_we cycle with those values, done next cycle; cmd_valid held during busy not re-accepted.
REQ-032 rst asserted at 3rd FM write of init -> outputs zero at once, init_done=0, next init restarts from fm_addr 0.
